// File: rtl/fifo_burst_drain.sv
// -----------------------------------------------------------------------------
// fifo_burst_drain
// Read-side master for a synchronous FIFO. It watches the FIFO fill level,
// pops words and forwards them downstream as framed bursts with first/last
// markers and a constant length field.
//   - A full burst carries BURST_LEN words and starts as soon as that many are
//     present.
//   - A partial burst (1..BURST_LEN-1 words) starts when the FIFO has sat
//     non-empty but short of a full burst for TIMEOUT idle cycles, or at once
//     on i_flush.
// The output is a single registered stage, so with i_ready held high a burst
// streams one beat per cycle.
//
// Ports
//   i_clk         clock
//   i_rst_n       asynchronous active-low reset
//   i_fifo_valid  FIFO head word valid (FIFO not empty)
//   i_fifo_data   FIFO head word
//   i_fifo_level  FIFO occupancy in words
//   o_fifo_ready  pop request; a pop happens when o_fifo_ready & i_fifo_valid
//   i_flush       start a partial burst with whatever the FIFO holds
//   i_ready       downstream accepts the current beat
//   o_valid       output beat valid
//   o_data        output beat data
//   o_first       first beat of a burst
//   o_last        last beat of a burst
//   o_len         burst length, constant for the whole burst
//   o_busy        a burst is in progress
// -----------------------------------------------------------------------------
module fifo_burst_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int LVL_WIDTH  = 9,
    parameter int BURST_LEN  = 16,
    parameter int TO_WIDTH   = 8,
    parameter int TIMEOUT    = 200
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fifo_valid,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic [LVL_WIDTH-1:0]  i_fifo_level,
    output logic                  o_fifo_ready,
    input  logic                  i_flush,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_first,
    output logic                  o_last,
    output logic [LVL_WIDTH-1:0]  o_len,
    output logic                  o_busy
);

    localparam logic [LVL_WIDTH-1:0] BURST_LEN_C = LVL_WIDTH'(BURST_LEN);
    localparam logic [TO_WIDTH-1:0]  TIMEOUT_C   = TO_WIDTH'(TIMEOUT);
    localparam logic [TO_WIDTH-1:0]  TO_MAX_C    = {TO_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                  state_q,      state_d;
    logic [LVL_WIDTH-1:0]    rem_cnt_q,    rem_cnt_d;
    logic [TO_WIDTH-1:0]     to_cnt_q,     to_cnt_d;
    logic                    first_pend_q, first_pend_d;
    logic                    valid_q,      valid_d;
    logic [DATA_WIDTH-1:0]   data_q,       data_d;
    logic                    first_q,      first_d;
    logic                    last_q,       last_d;
    logic [LVL_WIDTH-1:0]    len_q,        len_d;

    logic                    level_nz_s;
    logic                    fifo_ready_s;
    logic                    pop_s;
    logic                    start_s;
    logic [LVL_WIDTH-1:0]    start_len_s;

    // FIFO holds at least one word
    assign level_nz_s = (i_fifo_level != {LVL_WIDTH{1'b0}});

    // Next-state, pop request and output-stage update
    always_comb begin
        state_d      = state_q;
        rem_cnt_d    = rem_cnt_q;
        to_cnt_d     = to_cnt_q;
        first_pend_d = first_pend_q;
        valid_d      = valid_q;
        data_d       = data_q;
        first_d      = first_q;
        last_d       = last_q;
        len_d        = len_q;
        fifo_ready_s = 1'b0;
        pop_s        = 1'b0;
        start_s      = 1'b0;
        start_len_s  = {LVL_WIDTH{1'b0}};

        case (state_q)
            ST_IDLE: begin
                // The output stage is empty here, so the level is exact.
                if (i_fifo_level >= BURST_LEN_C) begin
                    start_s     = 1'b1;
                    start_len_s = BURST_LEN_C;
                end else if (level_nz_s && ((to_cnt_q == TIMEOUT_C) || i_flush)) begin
                    start_s     = 1'b1;
                    start_len_s = i_fifo_level;
                end else if (level_nz_s) begin
                    // Saturate so a long idle never wraps back below TIMEOUT.
                    if (to_cnt_q != TO_MAX_C) begin
                        to_cnt_d = to_cnt_q + TO_WIDTH'(1);
                    end else begin
                        to_cnt_d = to_cnt_q;
                    end
                end else begin
                    to_cnt_d = {TO_WIDTH{1'b0}};
                end

                if (start_s) begin
                    state_d      = ST_BURST;
                    len_d        = start_len_s;
                    rem_cnt_d    = start_len_s;
                    first_pend_d = 1'b1;
                    to_cnt_d     = {TO_WIDTH{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BURST: begin
                // Pop only when the output register is free or draining this cycle.
                fifo_ready_s = (rem_cnt_q != {LVL_WIDTH{1'b0}}) && (!valid_q || i_ready);
                pop_s        = fifo_ready_s && i_fifo_valid;

                if (pop_s) begin
                    data_d       = i_fifo_data;
                    valid_d      = 1'b1;
                    first_d      = first_pend_q;
                    last_d       = (rem_cnt_q == LVL_WIDTH'(1));
                    rem_cnt_d    = rem_cnt_q - LVL_WIDTH'(1);
                    first_pend_d = 1'b0;
                end else if (valid_q && i_ready) begin
                    // The last beat cannot overlap a pop: rem_cnt is already zero.
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BURST;
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            rem_cnt_q    <= {LVL_WIDTH{1'b0}};
            to_cnt_q     <= {TO_WIDTH{1'b0}};
            first_pend_q <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= {DATA_WIDTH{1'b0}};
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            len_q        <= {LVL_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            rem_cnt_q    <= rem_cnt_d;
            to_cnt_q     <= to_cnt_d;
            first_pend_q <= first_pend_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            first_q      <= first_d;
            last_q       <= last_d;
            len_q        <= len_d;
        end
    end

    assign o_fifo_ready = fifo_ready_s;
    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_first      = first_q;
    assign o_last       = last_q;
    assign o_len        = len_q;
    assign o_busy       = (state_q == ST_BURST);

endmodule

// File: tb/tb_fifo_burst_drain.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_drain
// Self-checking bench for fifo_burst_drain. A queue models the sync FIFO in
// front of the DUT; expected beats are queued as words are pushed and compared
// as the DUT hands them downstream.
// -----------------------------------------------------------------------------
module tb_fifo_burst_drain;

    localparam int DW  = 32;
    localparam int LW  = 9;
    localparam int BL  = 16;
    localparam int TOW = 8;
    localparam int TO  = 200;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          first;
        logic          last;
        logic [LW-1:0] len;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          fifo_valid;
    logic [DW-1:0] fifo_data;
    logic [LW-1:0] fifo_level;
    logic          fifo_ready;
    logic          flush;
    logic          ready;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_first;
    logic          o_last;
    logic [LW-1:0] o_len;
    logic          o_busy;

    logic [DW-1:0] fifo_q[$];
    beat_t         exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;

    // Values seen during the most recent cycle, taken on the falling edge
    logic          s_valid, s_first, s_last, s_busy, s_fready, s_rdy, s_acc;
    logic [DW-1:0] s_data;
    logic [LW-1:0] s_len;

    fifo_burst_drain #(
        .DATA_WIDTH (DW),
        .LVL_WIDTH  (LW),
        .BURST_LEN  (BL),
        .TO_WIDTH   (TOW),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_fifo_valid (fifo_valid),
        .i_fifo_data  (fifo_data),
        .i_fifo_level (fifo_level),
        .o_fifo_ready (fifo_ready),
        .i_flush      (flush),
        .i_ready      (ready),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_first      (o_first),
        .o_last       (o_last),
        .o_len        (o_len),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic sync_fifo();
        fifo_valid = (fifo_q.size() != 0);
        fifo_data  = fifo_valid ? fifo_q[0] : 32'h0;
        fifo_level = LW'(fifo_q.size());
    endtask

    task automatic push_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
        sync_fifo();
    endtask

    task automatic expect_burst(input logic [DW-1:0] base, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data  = base + DW'(i);
            b.first = (i == 0);
            b.last  = (i == n - 1);
            b.len   = LW'(n);
            exp_q.push_back(b);
        end
    endtask

    // One clock: sample at the falling edge, let the edge happen, update the FIFO model
    task automatic tick();
        logic pop;
        @(negedge clk);
        s_valid  = o_valid;
        s_data   = o_data;
        s_first  = o_first;
        s_last   = o_last;
        s_len    = o_len;
        s_busy   = o_busy;
        s_fready = fifo_ready;
        s_rdy    = ready;
        s_acc    = o_valid && ready;
        pop      = fifo_ready && fifo_valid;
        @(posedge clk);
        #1;
        if (pop) begin
            void'(fifo_q.pop_front());
            n_pop++;
        end
        sync_fifo();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ready = 1'b0;
        flush = 1'b0;
        sync_fifo();
        tick();
        tick();
        n_vec++;
        if ({o_valid, o_first, o_last, o_busy, fifo_ready} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags got v/f/l/busy/rdy=%b expected 00000",
                     {o_valid, o_first, o_last, o_busy, fifo_ready});
        end
        n_vec++;
        if (o_data !== 32'h0 || o_len !== 9'd0) begin
            n_err++;
            $display("FAIL reset_data got data=%h len=%0d expected 0/0", o_data, o_len);
        end
        rst_n = 1'b1;
        tick();
        tick();
        n_vec++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release got busy=%b valid=%b expected 0/0", o_busy, o_valid);
        end
    endtask

    task automatic test_full_burst();
        beat_t e;
        int    cyc;
        ready = 1'b1;
        push_words(32'h0, 16);
        expect_burst(32'h0, 16);
        tick();  // start decision registered
        n_vec++;
        if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_decision got busy=%b valid=%b expected 1/0", o_busy, o_valid);
        end
        tick();  // first pop registered
        n_vec++;
        if (o_valid !== 1'b1 || o_first !== 1'b1) begin
            n_err++;
            $display("FAIL full_latency got valid=%b first=%b expected 1/1", o_valid, o_first);
        end
        cyc = 0;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            tick();
            cyc++;
            if (s_acc) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({s_data, s_first, s_last, s_len} !== e) begin
                    n_err++;
                    $display("FAIL full_beat got %h/%b/%b/%0d expected %h/%b/%b/%0d",
                             s_data, s_first, s_last, s_len, e.data, e.first, e.last, e.len);
                end
            end
        end
        n_vec++;
        if (exp_q.size() != 0 || cyc != 16) begin
            n_err++;
            $display("FAIL full_throughput got %0d cycles, %0d missing; expected 16 cycles, 0 missing",
                     cyc, exp_q.size());
        end
        n_vec++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_len !== 9'd16) begin
            n_err++;
            $display("FAIL full_end got busy=%b valid=%b len=%0d expected 0/0/16", o_busy, o_valid, o_len);
        end
    endtask

    task automatic test_timeout();
        beat_t e;
        int    done;
        int    idle;
        ready = 1'b1;
        push_words(32'h1000, 40);
        expect_burst(32'h1000, 16);
        expect_burst(32'h1010, 16);
        expect_burst(32'h1020, 8);
        done = 0;
        idle = 0;
        for (int c = 0; c < 1000 && exp_q.size() != 0; c++) begin
            tick();
            if (done == 2 && !s_busy) idle++;
            if (s_acc) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({s_data, s_first, s_last, s_len} !== e) begin
                    n_err++;
                    $display("FAIL timeout_beat got %h/%b/%b/%0d expected %h/%b/%b/%0d",
                             s_data, s_first, s_last, s_len, e.data, e.first, e.last, e.len);
                end
                if (s_last) done++;
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL timeout_drain got %0d beats missing expected 0", exp_q.size());
        end
        n_vec++;
        if (idle != TO + 1) begin
            n_err++;
            $display("FAIL timeout_idle got %0d idle cycles expected %0d", idle, TO + 1);
        end
    endtask

    task automatic test_flush();
        beat_t e;
        ready = 1'b1;
        push_words(32'h2000, 3);
        expect_burst(32'h2000, 3);
        for (int i = 0; i < 4; i++) tick();
        n_vec++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_wait got busy=%b expected 0", o_busy);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if (o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL flush_start got busy=%b expected 1", o_busy);
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            tick();
            if (s_acc) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({s_data, s_first, s_last, s_len} !== e) begin
                    n_err++;
                    $display("FAIL flush_beat got %h/%b/%b/%0d expected %h/%b/%b/%0d",
                             s_data, s_first, s_last, s_len, e.data, e.first, e.last, e.len);
                end
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL flush_drain got %0d beats missing expected 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        beat_t         e;
        int            pop0;
        logic          p_stall;
        logic [DW-1:0] p_data;
        logic          p_first, p_last;
        logic          first_done;
        pop0       = n_pop;
        p_stall    = 1'b0;
        p_data     = 32'h0;
        p_first    = 1'b0;
        p_last     = 1'b0;
        first_done = 1'b0;
        push_words(32'h3000_0000, 32);
        expect_burst(32'h3000_0000, 16);
        expect_burst(32'h3000_0010, 16);
        for (int c = 0; c < 2000 && exp_q.size() != 0; c++) begin
            ready = ($urandom_range(0, 9) < 6);
            tick();
            if (p_stall) begin
                n_vec++;
                if (!s_valid || s_data !== p_data || s_first !== p_first || s_last !== p_last) begin
                    n_err++;
                    $display("FAIL bp_stable got %b/%h/%b/%b expected 1/%h/%b/%b",
                             s_valid, s_data, s_first, s_last, p_data, p_first, p_last);
                end
            end
            if (s_acc) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({s_data, s_first, s_last, s_len} !== e) begin
                    n_err++;
                    $display("FAIL bp_beat got %h/%b/%b/%0d expected %h/%b/%b/%0d",
                             s_data, s_first, s_last, s_len, e.data, e.first, e.last, e.len);
                end
                if (s_last && !first_done) begin
                    first_done = 1'b1;
                    n_vec++;
                    if (n_pop - pop0 != BL) begin
                        n_err++;
                        $display("FAIL bp_pops1 got %0d pops expected %0d", n_pop - pop0, BL);
                    end
                end
            end
            p_stall = s_valid && !s_rdy;
            p_data  = s_data;
            p_first = s_first;
            p_last  = s_last;
        end
        n_vec++;
        if (exp_q.size() != 0 || n_pop - pop0 != 2 * BL) begin
            n_err++;
            $display("FAIL bp_total got %0d pops, %0d missing expected %0d pops, 0 missing",
                     n_pop - pop0, exp_q.size(), 2 * BL);
        end
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (s_valid !== 1'b0) begin
                n_err++;
                $display("FAIL bp_extra got valid=%b data=%h expected valid=0", s_valid, s_data);
            end
        end
    endtask

    task automatic test_flush_empty();
        ready = 1'b1;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (s_busy !== 1'b0 || s_valid !== 1'b0 || s_fready !== 1'b0) begin
                n_err++;
                $display("FAIL empty_flush got busy=%b valid=%b fifo_ready=%b expected 0/0/0",
                         s_busy, s_valid, s_fready);
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_midburst();
        beat_t e;
        int    beats;
        int    rem;
        ready = 1'b1;
        push_words(32'h4000, 16);
        expect_burst(32'h4000, 16);
        beats = 0;
        for (int c = 0; c < 100 && beats < 5; c++) begin
            tick();
            if (s_acc) begin
                e = exp_q.pop_front();
                beats++;
                n_vec++;
                if ({s_data, s_first, s_last, s_len} !== e) begin
                    n_err++;
                    $display("FAIL rst_beat got %h/%b/%b/%0d expected %h/%b/%b/%0d",
                             s_data, s_first, s_last, s_len, e.data, e.first, e.last, e.len);
                end
            end
        end
        n_vec++;
        if (beats != 5) begin
            n_err++;
            $display("FAIL rst_prefix got %0d beats expected 5", beats);
        end
        rst_n = 1'b0;
        #2;
        n_vec++;
        if ({o_valid, o_first, o_last, o_busy, fifo_ready} !== 5'b0 || o_data !== 32'h0 || o_len !== 9'd0) begin
            n_err++;
            $display("FAIL rst_async got v/f/l/busy/rdy=%b data=%h len=%0d expected 00000/0/0",
                     {o_valid, o_first, o_last, o_busy, fifo_ready}, o_data, o_len);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_idle got busy=%b valid=%b expected 0/0", o_busy, o_valid);
        end
        rem = fifo_q.size();
        for (int i = 0; i < rem; i++) begin
            e.data  = fifo_q[i];
            e.first = (i == 0);
            e.last  = (i == rem - 1);
            e.len   = LW'(rem);
            exp_q.push_back(e);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            tick();
            if (s_acc) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({s_data, s_first, s_last, s_len} !== e) begin
                    n_err++;
                    $display("FAIL rst_redrain got %h/%b/%b/%0d expected %h/%b/%b/%0d",
                             s_data, s_first, s_last, s_len, e.data, e.first, e.last, e.len);
                end
            end
        end
        n_vec++;
        if (exp_q.size() != 0 || fifo_q.size() != 0) begin
            n_err++;
            $display("FAIL rst_redrain_done got %0d missing, %0d left in fifo expected 0/0",
                     exp_q.size(), fifo_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_timeout();
        test_flush();
        test_backpressure();
        test_flush_empty();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
